// File: rtl/v_pkg.sv
// Shared vector definitions: element-width / group-multiplier codes, sequencer
// states, default geometry and the funct6 opcodes also used by the decoder.
package v_pkg;

  localparam int V_VLEN_DEF = 128;
  localparam int V_DW_DEF   = 64;

  typedef enum logic [2:0] {
    SEW_8  = 3'd0,
    SEW_16 = 3'd1,
    SEW_32 = 3'd2,
    SEW_64 = 3'd3
  } sew_e;

  typedef enum logic [2:0] {
    LMUL_1 = 3'd0,
    LMUL_2 = 3'd1,
    LMUL_4 = 3'd2,
    LMUL_8 = 3'd3
  } lmul_e;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } seq_state_e;

  localparam logic [5:0] F6_VADD = 6'b000000;
  localparam logic [5:0] F6_VSUB = 6'b000010;
  localparam logic [5:0] F6_VAND = 6'b001001;
  localparam logic [5:0] F6_VOR  = 6'b001010;
  localparam logic [5:0] F6_VXOR = 6'b001011;

  function automatic logic sew_legal(input logic [2:0] code);
    return code <= 3'(SEW_64);
  endfunction

  function automatic logic [3:0] sew_bytes(input logic [2:0] code);
    return 4'd1 << code[1:0];
  endfunction

  // Fractional and reserved group multipliers are not supported.
  function automatic logic lmul_legal(input logic [2:0] code);
    return code <= 3'(LMUL_8);
  endfunction

  function automatic logic [3:0] lmul_factor(input logic [2:0] code);
    return 4'd1 << code[1:0];
  endfunction

endpackage

// File: rtl/v_mask_gen.sv
// Remaining-byte count to per-beat byte-enable mask: lane i is enabled when
// more than i bytes remain, so a count >= DWB yields all ones.
module v_mask_gen #(
  parameter int DW = 64,
  parameter int RW = 8
) (
  input  logic [RW-1:0]   rem,
  output logic [DW/8-1:0] mask
);

  for (genvar gi = 0; gi < DW / 8; gi++) begin : g_lane
    assign mask[gi] = (rem > RW'(gi));
  end

endmodule

// File: rtl/v_elem_seq.sv
// Vector element sequencer: latches one instruction plus its vl/vsew/vlmul and
// strip-mines the register group into DW-bit micro-ops for the lane datapath.
module v_elem_seq
  import v_pkg::*;
#(
  parameter int VLEN = V_VLEN_DEF,
  parameter int DW   = V_DW_DEF,
  localparam int BPR = VLEN / DW,
  localparam int DWB = DW / 8,
  localparam int HW  = (BPR > 1) ? $clog2(BPR) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [4:0]    vl,
  input  logic [2:0]    vlmul,
  input  logic [2:0]    vsew,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [4:0]    in_vd,
  input  logic [4:0]    in_vs1,
  input  logic [4:0]    in_vs2,
  input  logic [5:0]    in_funct6,
  output logic          uop_valid,
  input  logic          uop_ready,
  output logic [4:0]    uop_vd,
  output logic [4:0]    uop_vs1,
  output logic [4:0]    uop_vs2,
  output logic [5:0]    uop_funct6,
  output logic [HW-1:0] uop_half,
  output logic [DWB-1:0] uop_mask,
  output logic          uop_last,
  output logic          done,
  output logic          illegal
);

  localparam int DWB_LG  = $clog2(DWB);
  localparam int BPR_LG  = $clog2(BPR);
  localparam int VLEN_LG = $clog2(VLEN / 8);

  seq_state_e state_q, state_d;
  logic [4:0] vd_q, vd_d;
  logic [4:0] vs1_q, vs1_d;
  logic [4:0] vs2_q, vs2_d;
  logic [5:0] funct6_q, funct6_d;
  logic [7:0] bytes_q, bytes_d;
  logic [4:0] last_beat_q, last_beat_d;
  logic [4:0] beat_q, beat_d;
  logic       done_q, done_d;
  logic       illegal_q, illegal_d;

  // Configuration decode, evaluated on the live CSR/specifier inputs.
  logic [3:0] lmul_mask;
  logic       misaligned;
  logic       dec_illegal;
  logic [4:0] vlmax_lg;
  logic [4:0] vlmax_small;
  logic [4:0] dec_elems;
  logic [7:0] dec_bytes;
  logic [8:0] dec_beats;
  logic [4:0] dec_last_beat;

  always_comb begin
    lmul_mask   = lmul_factor(vlmul) - 4'd1;
    misaligned  = |((in_vd[3:0] | in_vs1[3:0] | in_vs2[3:0]) & lmul_mask);
    dec_illegal = !sew_legal(vsew) || !lmul_legal(vlmul) || misaligned;

    // log2(VLMAX) = log2(LMUL) + log2(VLEN/8) - log2(SEWB)
    vlmax_lg    = 5'(vlmul[1:0]) + 5'(VLEN_LG) - 5'(vsew[1:0]);
    vlmax_small = 5'd1 << vlmax_lg;
    if (vlmax_lg >= 5'd5) begin
      dec_elems = vl;
    end else begin
      dec_elems = (vl > vlmax_small) ? vlmax_small : vl;
    end

    dec_bytes     = 8'(dec_elems) << vsew[1:0];
    dec_beats     = (9'(dec_bytes) + 9'(DWB - 1)) >> DWB_LG;
    dec_last_beat = 5'(dec_beats - 9'd1);
  end

  always_comb begin
    state_d     = state_q;
    vd_d        = vd_q;
    vs1_d       = vs1_q;
    vs2_d       = vs2_q;
    funct6_d    = funct6_q;
    bytes_d     = bytes_q;
    last_beat_d = last_beat_q;
    beat_d      = beat_q;
    done_d      = 1'b0;
    illegal_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (dec_illegal) begin
            illegal_d = 1'b1;
          end else if (dec_elems == 5'd0) begin
            done_d = 1'b1;
          end else begin
            state_d     = ISSUE;
            vd_d        = in_vd;
            vs1_d       = in_vs1;
            vs2_d       = in_vs2;
            funct6_d    = in_funct6;
            bytes_d     = dec_bytes;
            last_beat_d = dec_last_beat;
            beat_d      = 5'd0;
          end
        end
      end
      ISSUE: begin
        if (uop_ready) begin
          if (beat_q == last_beat_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            beat_d = beat_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      vd_q        <= '0;
      vs1_q       <= '0;
      vs2_q       <= '0;
      funct6_q    <= '0;
      bytes_q     <= '0;
      last_beat_q <= '0;
      beat_q      <= '0;
      done_q      <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      vd_q        <= vd_d;
      vs1_q       <= vs1_d;
      vs2_q       <= vs2_d;
      funct6_q    <= funct6_d;
      bytes_q     <= bytes_d;
      last_beat_q <= last_beat_d;
      beat_q      <= beat_d;
      done_q      <= done_d;
      illegal_q   <= illegal_d;
    end
  end

  // Micro-op fields derive from the held beat index, so they stay stable
  // under back-pressure; they read as zero whenever no beat is offered.
  logic       issuing;
  logic [4:0] reg_off;
  logic [7:0] rem_bytes;

  assign issuing   = (state_q == ISSUE);
  assign reg_off   = beat_q >> BPR_LG;
  assign rem_bytes = issuing ? (bytes_q - (8'(beat_q) << DWB_LG)) : 8'd0;

  v_mask_gen #(
    .DW (DW),
    .RW (8)
  ) u_mask_gen (
    .rem  (rem_bytes),
    .mask (uop_mask)
  );

  assign in_ready   = (state_q == IDLE) && !rst;
  assign uop_valid  = issuing;
  assign uop_vd     = issuing ? vd_q + reg_off : 5'd0;
  assign uop_vs1    = issuing ? vs1_q + reg_off : 5'd0;
  assign uop_vs2    = issuing ? vs2_q + reg_off : 5'd0;
  assign uop_funct6 = issuing ? funct6_q : 6'd0;
  assign uop_half   = issuing ? HW'(beat_q & 5'(BPR - 1)) : '0;
  assign uop_last   = issuing && (beat_q == last_beat_q);
  assign done       = done_q;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_v_elem_seq.sv
// Self-checking bench for v_elem_seq: directed scenarios plus randomized
// instructions, each compared against a per-instruction arithmetic model.
module tb_v_elem_seq;

  localparam int VLEN = 128;
  localparam int DW   = 64;
  localparam int BPR  = VLEN / DW;
  localparam int DWB  = DW / 8;

  logic       clk;
  logic       rst;
  logic [4:0] vl;
  logic [2:0] vlmul;
  logic [2:0] vsew;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_vd, in_vs1, in_vs2;
  logic [5:0] in_funct6;
  logic       uop_valid;
  logic       uop_ready;
  logic [4:0] uop_vd, uop_vs1, uop_vs2;
  logic [5:0] uop_funct6;
  logic [0:0] uop_half;
  logic [7:0] uop_mask;
  logic       uop_last;
  logic       done;
  logic       illegal;

  int n_cmp = 0;
  int n_bad = 0;

  v_elem_seq #(.VLEN(VLEN), .DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .vl         (vl),
    .vlmul      (vlmul),
    .vsew       (vsew),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_vd      (in_vd),
    .in_vs1     (in_vs1),
    .in_vs2     (in_vs2),
    .in_funct6  (in_funct6),
    .uop_valid  (uop_valid),
    .uop_ready  (uop_ready),
    .uop_vd     (uop_vd),
    .uop_vs1    (uop_vs1),
    .uop_vs2    (uop_vs2),
    .uop_funct6 (uop_funct6),
    .uop_half   (uop_half),
    .uop_mask   (uop_mask),
    .uop_last   (uop_last),
    .done       (done),
    .illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: apply the vector configuration rules with plain arithmetic.
  function automatic void model(input int sew, input int lmul_c, input int vl_i,
                                input int vd, input int vs1, input int vs2,
                                output bit legal, output int bytes, output int beats);
    int lm, sewb, vlmax, elems;
    legal = 0;
    bytes = 0;
    beats = 0;
    if (sew > 3 || lmul_c > 3) return;
    lm   = 2 ** lmul_c;
    sewb = 2 ** sew;
    if ((vd % lm) != 0 || (vs1 % lm) != 0 || (vs2 % lm) != 0) return;
    legal = 1;
    vlmax = lm * VLEN / (8 * sewb);
    elems = (vl_i < vlmax) ? vl_i : vlmax;
    bytes = elems * sewb;
    beats = (bytes + DWB - 1) / DWB;
  endfunction

  task automatic run(input string name, input int sew, input int lmul_c, input int vl_i,
                     input int vd, input int vs1, input int vs2, input int f6,
                     input int stall_beat, input bit rnd_ready);
    bit legal;
    int bytes, beats, b, cyc, stalls, rem, exp_mask;
    bit rdy;
    model(sew, lmul_c, vl_i, vd, vs1, vs2, legal, bytes, beats);
    $display("[%0t] %s: sew=%0d lmul=%0d vl=%0d vd=%0d vs1=%0d vs2=%0d -> legal=%0d bytes=%0d beats=%0d",
             $time, name, sew, lmul_c, vl_i, vd, vs1, vs2, legal, bytes, beats);
    vsew      = 3'(sew);
    vlmul     = 3'(lmul_c);
    vl        = 5'(vl_i);
    in_vd     = 5'(vd);
    in_vs1    = 5'(vs1);
    in_vs2    = 5'(vs2);
    in_funct6 = 6'(f6);
    in_valid  = 1'b1;
    chk($sformatf("%s.accept_ready", name), 32'(in_ready), 32'd1);
    step();
    in_valid  = 1'b0;
    vsew      = 3'($urandom);
    vlmul     = 3'($urandom);
    vl        = 5'($urandom);
    in_vd     = 5'($urandom);
    in_vs1    = 5'($urandom);
    in_vs2    = 5'($urandom);
    in_funct6 = 6'($urandom);
    if (!legal) begin
      chk($sformatf("%s.illegal", name), 32'(illegal), 32'd1);
      chk($sformatf("%s.ill_valid", name), 32'(uop_valid), 32'd0);
      chk($sformatf("%s.ill_ready", name), 32'(in_ready), 32'd1);
      chk($sformatf("%s.ill_done", name), 32'(done), 32'd0);
      step();
      chk($sformatf("%s.illegal_end", name), 32'(illegal), 32'd0);
      return;
    end
    if (beats == 0) begin
      chk($sformatf("%s.vl0_done", name), 32'(done), 32'd1);
      chk($sformatf("%s.vl0_valid", name), 32'(uop_valid), 32'd0);
      chk($sformatf("%s.vl0_ready", name), 32'(in_ready), 32'd1);
      chk($sformatf("%s.vl0_illegal", name), 32'(illegal), 32'd0);
      step();
      chk($sformatf("%s.vl0_done_end", name), 32'(done), 32'd0);
      chk($sformatf("%s.vl0_valid_end", name), 32'(uop_valid), 32'd0);
      return;
    end
    b = 0;
    cyc = 0;
    stalls = 0;
    while (b < beats && cyc < 400) begin
      rem = bytes - b * DWB;
      exp_mask = (rem >= DWB) ? 32'hFF : ((1 << rem) - 1);
      chk($sformatf("%s.b%0d.valid", name, b), 32'(uop_valid), 32'd1);
      chk($sformatf("%s.b%0d.in_ready", name, b), 32'(in_ready), 32'd0);
      chk($sformatf("%s.b%0d.done", name, b), 32'(done), 32'd0);
      chk($sformatf("%s.b%0d.vd", name, b), 32'(uop_vd), 32'((vd + b / BPR) % 32));
      chk($sformatf("%s.b%0d.vs1", name, b), 32'(uop_vs1), 32'((vs1 + b / BPR) % 32));
      chk($sformatf("%s.b%0d.vs2", name, b), 32'(uop_vs2), 32'((vs2 + b / BPR) % 32));
      chk($sformatf("%s.b%0d.funct6", name, b), 32'(uop_funct6), 32'(f6));
      chk($sformatf("%s.b%0d.half", name, b), 32'(uop_half), 32'(b % BPR));
      chk($sformatf("%s.b%0d.mask", name, b), 32'(uop_mask), 32'(exp_mask));
      chk($sformatf("%s.b%0d.last", name, b), 32'(uop_last), 32'(b == beats - 1));
      rdy = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (b == stall_beat && stalls < 3) begin
        rdy = 1'b0;
        stalls++;
      end
      uop_ready = rdy;
      step();
      if (rdy) b++;
      cyc++;
    end
    uop_ready = 1'b0;
    chk($sformatf("%s.beats_issued", name), 32'(b), 32'(beats));
    chk($sformatf("%s.done", name), 32'(done), 32'd1);
    chk($sformatf("%s.end_valid", name), 32'(uop_valid), 32'd0);
    chk($sformatf("%s.end_ready", name), 32'(in_ready), 32'd1);
    step();
    chk($sformatf("%s.done_end", name), 32'(done), 32'd0);
  endtask

  initial begin
    int sew, lm, vd, vs1, vs2;
    rst       = 1'b1;
    vl        = '0;
    vlmul     = '0;
    vsew      = '0;
    in_valid  = 1'b0;
    in_vd     = '0;
    in_vs1    = '0;
    in_vs2    = '0;
    in_funct6 = '0;
    uop_ready = 1'b0;
    step();
    step();
    chk("reset.valid", 32'(uop_valid), 32'd0);
    chk("reset.done", 32'(done), 32'd0);
    chk("reset.illegal", 32'(illegal), 32'd0);
    chk("reset.vd", 32'(uop_vd), 32'd0);
    chk("reset.mask", 32'(uop_mask), 32'd0);
    chk("reset.last", 32'(uop_last), 32'd0);
    chk("reset.half", 32'(uop_half), 32'd0);
    rst = 1'b0;
    #1;
    chk("reset.in_ready", 32'(in_ready), 32'd1);

    run("sew32_vl3", 2, 0, 3, 4, 8, 12, 6'h00, -1, 1'b0);
    run("sew64_clamp", 3, 1, 5, 8, 0, 2, 6'h02, -1, 1'b0);
    run("ill_align", 0, 2, 4, 6, 0, 0, 6'h09, -1, 1'b0);
    run("ill_sew5", 5, 0, 4, 2, 0, 0, 6'h09, -1, 1'b0);
    run("ill_lmul5", 0, 5, 4, 2, 0, 0, 6'h09, -1, 1'b0);
    run("vl0", 1, 0, 0, 3, 0, 0, 6'h0a, -1, 1'b0);
    run("sew8_stall", 0, 1, 17, 2, 4, 6, 6'h0b, 1, 1'b0);

    // Reset while beat 1 of a four-beat instruction is pending.
    $display("[%0t] reset_mid_issue: sew=3 lmul=1 vl=4 vd=8", $time);
    vsew = 3'd3; vlmul = 3'd1; vl = 5'd4;
    in_vd = 5'd8; in_vs1 = 5'd0; in_vs2 = 5'd2; in_funct6 = 6'h01;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    uop_ready = 1'b1;
    chk("rstmid.b0_valid", 32'(uop_valid), 32'd1);
    step();
    uop_ready = 1'b0;
    chk("rstmid.b1_half", 32'(uop_half), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("rstmid.valid", 32'(uop_valid), 32'd0);
    chk("rstmid.in_ready", 32'(in_ready), 32'd1);
    chk("rstmid.done", 32'(done), 32'd0);
    step();
    chk("rstmid.done_after", 32'(done), 32'd0);
    run("after_reset", 3, 1, 4, 8, 0, 2, 6'h01, -1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      sew = $urandom_range(0, 4);
      lm  = $urandom_range(0, 4);
      vd  = $urandom_range(0, 31);
      vs1 = $urandom_range(0, 31);
      vs2 = $urandom_range(0, 31);
      if (lm < 4 && $urandom_range(0, 7) != 0) begin
        vd  = vd  - (vd  % (2 ** lm));
        vs1 = vs1 - (vs1 % (2 ** lm));
        vs2 = vs2 - (vs2 % (2 ** lm));
      end
      run($sformatf("rnd%0d", i), sew, lm, $urandom_range(0, 31), vd, vs1, vs2,
          $urandom_range(0, 63), -1, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
